// File: rtl/storage_compare_checker_pkg.sv
// Shared state encoding and default widths for the storage compare checker.
package storage_compare_checker_pkg;

    localparam int CNT_W_DEF = 8;
    localparam int LEN_W_DEF = 16;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WARMUP = 2'd1;
    localparam logic [1:0] ST_CHECK  = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

endpackage

// File: rtl/storage_compare_checker_sat_counter.sv
// Width-parameterised saturating counter with synchronous clear.
module sat_counter
    import storage_compare_checker_pkg::*;
#(
    parameter int W = CNT_W_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !(&cnt)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/storage_compare_checker.sv
// Observes latch / posedge FF / negedge FF outputs and counts mismatches
// against the values predicted from the d history.
module storage_compare_checker
    import storage_compare_checker_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int LEN_W       = LEN_W_DEF,
    parameter int WARMUP      = 2,
    parameter int STOP_ON_ERR = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] num_checks,
    input  logic             d,
    input  logic             qa,
    input  logic             qb,
    input  logic             qc,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_a,
    output logic [CNT_W-1:0] err_b,
    output logic [CNT_W-1:0] err_c
);

    logic [1:0]       state;
    logic [LEN_W-1:0] n_lat;
    logic [LEN_W-1:0] cyc;
    logic [LEN_W-1:0] cyc_nxt;
    logic             d_prev;
    logic             d_mid;
    logic             pass_r;
    logic             pass_now;
    logic             in_check;
    logic             clr;
    logic             mis_a;
    logic             mis_b;
    logic             mis_c;
    logic             any_mis;

    // d as seen at the falling edge, when the latch closes and qc loads
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) d_mid <= 1'b0;
        else        d_mid <= d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) d_prev <= 1'b0;
        else        d_prev <= d;
    end

    assign in_check = (state == ST_CHECK);
    assign clr      = (state == ST_IDLE) && start;
    assign mis_a    = in_check && (qa != qc);
    assign mis_b    = in_check && (qb != d_prev);
    assign mis_c    = in_check && (qc != d_mid);
    assign any_mis  = mis_a || mis_b || mis_c;
    assign cyc_nxt  = cyc + LEN_W'(1);
    assign pass_now = ~|{err_a, err_b, err_c};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            n_lat  <= '0;
            cyc    <= '0;
            pass_r <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        n_lat  <= num_checks;
                        cyc    <= '0;
                        pass_r <= 1'b0;
                        state  <= ST_WARMUP;
                    end
                end
                ST_WARMUP: begin
                    if (cyc == LEN_W'(WARMUP - 1)) begin
                        cyc   <= '0;
                        state <= (n_lat == '0) ? ST_DONE : ST_CHECK;
                    end else begin
                        cyc <= cyc_nxt;
                    end
                end
                ST_CHECK: begin
                    cyc <= cyc_nxt;
                    if (cyc_nxt == n_lat || (STOP_ON_ERR != 0 && any_mis))
                        state <= ST_DONE;
                end
                ST_DONE: begin
                    pass_r <= pass_now;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state == ST_WARMUP) || (state == ST_CHECK);
    assign done = (state == ST_DONE);
    assign pass = done ? pass_now : pass_r;

    sat_counter #(.W(CNT_W)) u_cnt_a (
        .clk(clk), .rst_n(rst_n), .clr(clr), .inc(mis_a), .cnt(err_a)
    );

    sat_counter #(.W(CNT_W)) u_cnt_b (
        .clk(clk), .rst_n(rst_n), .clr(clr), .inc(mis_b), .cnt(err_b)
    );

    sat_counter #(.W(CNT_W)) u_cnt_c (
        .clk(clk), .rst_n(rst_n), .clr(clr), .inc(mis_c), .cnt(err_c)
    );

endmodule

// File: doc/storage_compare_checker.md
Name: storage_compare_checker

Overview:
- Self-checking monitor that sits on the outputs of the storage-element comparison block (latch Qa, posedge FF Qb, negedge FF Qc). It is the receiving/observing end of the stimulus driver.
- Samples D, Qa, Qb and Qc on every rising clk edge. Predicts the expected values from D history and counts mismatches per element.
- Reports pass/fail after a programmed number of checked cycles.
- Single clock domain. Purely observational: it never drives the DUT.

Parameters:
- CNT_W, 8, width of each mismatch counter (counters saturate at 2^CNT_W-1).
- LEN_W, 16, width of the check-length input and cycle counter.
- WARMUP, 2, cycles after start before comparisons begin (lets X/unknown state flush).
- STOP_ON_ERR, 0, 1 = halt at first mismatch; 0 = run full length.

Ports:
- clk  in  1  system clock; same clock that drives the DUT storage elements.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a check run when idle.
- num_checks  in  LEN_W  number of comparison cycles; latched on start.
- d  in  1  DUT data input (same net the DUT sees).
- qa  in  1  latch output (transparent while clk high).
- qb  in  1  posedge flip-flop output.
- qc  in  1  negedge flip-flop output.
- busy  out  1  high while in WARMUP or CHECK.
- done  out  1  one-cycle pulse when a run ends.
- pass  out  1  valid from done until next start; 1 = zero mismatches.
- err_a  out  CNT_W  latch mismatch count.
- err_b  out  CNT_W  posedge FF mismatch count.
- err_c  out  CNT_W  negedge FF mismatch count.

Behaviour:
- Reset (async, rst_n=0): state IDLE, busy=0, done=0, pass=0, err_a/b/c=0, d_prev=0, counters=0. Reset mid-run aborts the run immediately; no done pulse is issued.
- Rising clk samples, all at the same edge:
  - Qb is expected to equal d_prev, the d value registered at the previous rising edge.
  - Qc is expected to hold d as of the last falling edge.
  - Qa is expected to hold d as of the last falling edge, because the latch closes at the falling edge.
  - Therefore the checks are qb==d_prev, qa==qc, and qc==d_mid. d_mid is d sampled by a negedge register internal to this block. That register is the only negedge element; it is not an output.
- States:
  - IDLE: on start, latch num_checks, clear err_a/b/c and pass, go to WARMUP. start is ignored when not IDLE.
  - WARMUP: count WARMUP cycles with no comparisons, then go to CHECK. If num_checks==0, go straight from WARMUP to DONE.
  - CHECK: each cycle, increment the mismatching counters, saturating, never wrapping. Increment the cycle counter. When the cycle counter reaches num_checks, go to DONE. If STOP_ON_ERR=1 and any mismatch occurs this cycle, go to DONE; that cycle's counts are still recorded.
  - DONE: one cycle. done=1, pass=(err_a|err_b|err_c)==0, then go to IDLE. Counters and pass hold until the next start.
- busy=1 exactly in WARMUP and CHECK.
- Latency: done asserts on the cycle after the last checked edge.
- Simultaneous events: start together with reset is ignored because reset dominates. A multi-element mismatch in one cycle increments each affected counter.
- Mismatch counting is gated only by state; d is sampled continuously so d_prev is valid at the first CHECK edge.

Decomposition:
- Shared package holds:
  - State encoding constants: ST_IDLE, ST_WARMUP, ST_CHECK, ST_DONE.
  - CNT_W/LEN_W defaults.
- One natural sub-module: sat_counter (width-parameterised saturating counter with clear and increment). It is instantiated three times for err_a/b/c.

Test Plan:
1. Reset with rst_n=0 mid-CHECK -> all outputs 0 and state IDLE within the same cycle; no done pulse.
2. Correct DUT, d toggled every 15 ns with clk period 20 ns, num_checks=20 -> busy high 22 cycles, done pulse, pass=1, err_a=err_b=err_c=0.
3. Inject qb forced to 0 while d=1 for 3 checked cycles, num_checks=10 -> err_b=3, err_a=err_c=0, pass=0.
4. Stuck-high latch, qa=1 with d=0 constant, num_checks=300, CNT_W=8 -> err_a saturates at 255, pass=0, done at cycle 302.
5. STOP_ON_ERR=1, qc mismatch first occurs on 5th checked cycle -> err_c=1 (err_a=1 also, since qa!=qc), done the next cycle, busy low after only 5 checks.
6. num_checks=0 -> WARMUP 2 cycles, done pulse, pass=1; a second start pulse while busy has no effect.
